dbg_cmd_ctrl: RTL and testbench

DBG_CMD_CTRL -- requirements
Module: dbg_cmd_ctrl

---
 rtl/dbg_cmd_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dbg_cmd_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_ctrl.sv
// rtl/dbg_cmd_ctrl.sv - debug command controller: word-stream commands to CPU halt control and memory accesses
//
// Purpose: decodes commands from a word receiver, runs halt/resume/status
// commands and single memory reads/writes, and returns one response word per
// command through a word transmitter.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   rx_ready, rx_word    one-cycle pulse qualifying a received 32-bit word
//   tx_start, tx_word    one-cycle send pulse; response word held until next send
//   tx_busy              transmitter busy, SEND waits while high
//   mem_rd, mem_wr       level access requests, held until mem_ack
//   mem_addr, mem_wdata  access address / write data
//   mem_rdata, mem_ack   read data and one-cycle completion
//   halt                 CPU halt request level
//   busy                 high whenever a command is in progress
module dbg_cmd_ctrl #(
  parameter int CLK_RATE    = 50,
  parameter int CMD_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [31:0] rx_word,
  output logic        tx_start,
  output logic [31:0] tx_word,
  input  logic        tx_busy,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        halt,
  output logic        busy
);

  localparam int TIMEOUT_CLKS = CLK_RATE * CMD_TIMEOUT * 1000;
  localparam int CW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CLKS);

  localparam logic [7:0] OP_STATUS = 8'h01;
  localparam logic [7:0] OP_HALT   = 8'h02;
  localparam logic [7:0] OP_RESUME = 8'h03;
  localparam logic [7:0] OP_MEM_RD = 8'h04;
  localparam logic [7:0] OP_MEM_WR = 8'h05;

  localparam logic [31:0] RESP_TIMEOUT = 32'hFFFF_FFFD;
  localparam logic [31:0] RESP_NOHALT  = 32'hFFFF_FFFE;
  localparam logic [31:0] RESP_BADOP   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, MEM_REQ, SEND} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   resp, resp_nx;
  logic          is_wr, is_wr_nx;
  logic          overrun, overrun_nx;
  logic          tx_start_nx, mem_rd_nx, mem_wr_nx, halt_nx, busy_nx;
  logic [31:0]   tx_word_nx, mem_addr_nx, mem_wdata_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      resp      <= '0;
      is_wr     <= 1'b0;
      overrun   <= 1'b0;
      tx_start  <= 1'b0;
      tx_word   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halt      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      resp      <= resp_nx;
      is_wr     <= is_wr_nx;
      overrun   <= overrun_nx;
      tx_start  <= tx_start_nx;
      tx_word   <= tx_word_nx;
      mem_rd    <= mem_rd_nx;
      mem_wr    <= mem_wr_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      halt      <= halt_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    resp_nx      = resp;
    is_wr_nx     = is_wr;
    overrun_nx   = overrun;
    tx_start_nx  = 1'b0;
    tx_word_nx   = tx_word;
    mem_rd_nx    = mem_rd;
    mem_wr_nx    = mem_wr;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    halt_nx      = halt;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rx_ready) begin
          state_nx = SEND;
          case (rx_word[7:0])
            OP_STATUS: begin
              resp_nx    = {30'b0, overrun, halt};
              overrun_nx = 1'b0;
            end
            OP_HALT: begin
              halt_nx = 1'b1;
              resp_nx = '0;
            end
            OP_RESUME: begin
              halt_nx = 1'b0;
              resp_nx = '0;
            end
            OP_MEM_RD, OP_MEM_WR: begin
              // Memory access is only legal with the CPU halted; otherwise
              // reject at once without consuming any argument words.
              if (halt) begin
                is_wr_nx = (rx_word[7:0] == OP_MEM_WR);
                state_nx = GET_ADDR;
              end else begin
                resp_nx = RESP_NOHALT;
              end
            end
            default: resp_nx = RESP_BADOP;
          endcase
        end
      end

      GET_ADDR: begin
        if (rx_ready) begin
          cnt_nx      = '0;
          mem_addr_nx = rx_word;
          if (is_wr) begin
            state_nx = GET_DATA;
          end else begin
            state_nx  = MEM_REQ;
            mem_rd_nx = 1'b1;
          end
        end else if (cnt == TO_MAX) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      GET_DATA: begin
        if (rx_ready) begin
          cnt_nx       = '0;
          mem_wdata_nx = rx_word;
          mem_wr_nx    = 1'b1;
          state_nx     = MEM_REQ;
        end else if (cnt == TO_MAX) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      MEM_REQ: begin
        // Words arriving mid-access are lost; the host learns via STATUS.
        if (rx_ready) overrun_nx = 1'b1;
        if (mem_ack) begin
          resp_nx   = mem_rd ? mem_rdata : 32'h0;
          mem_rd_nx = 1'b0;
          mem_wr_nx = 1'b0;
          cnt_nx    = '0;
          state_nx  = SEND;
        end else if (cnt == TO_MAX) begin
          resp_nx   = RESP_TIMEOUT;
          mem_rd_nx = 1'b0;
          mem_wr_nx = 1'b0;
          cnt_nx    = '0;
          state_nx  = SEND;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      SEND: begin
        cnt_nx = '0;
        if (rx_ready) overrun_nx = 1'b1;
        if (!tx_busy) begin
          tx_start_nx = 1'b1;
          tx_word_nx  = resp;
          state_nx    = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_dbg_cmd_ctrl.sv
// tb/tb_dbg_cmd_ctrl.sv - directed scoreboard bench for dbg_cmd_ctrl
module tb_dbg_cmd_ctrl;

  localparam int CLK_RATE    = 1;
  localparam int CMD_TIMEOUT = 1;
  localparam int T           = CLK_RATE * CMD_TIMEOUT * 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ready;
  logic [31:0] rx_word;
  logic        tx_start;
  logic [31:0] tx_word;
  logic        tx_busy;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        halt, busy;

  int checks    = 0;
  int errors    = 0;
  int tx_count  = 0;
  int rd_cycles = 0;
  logic [31:0] exp_q[$];

  dbg_cmd_ctrl #(.CLK_RATE(CLK_RATE), .CMD_TIMEOUT(CMD_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rx_ready(rx_ready), .rx_word(rx_word),
    .tx_start(tx_start), .tx_word(tx_word), .tx_busy(tx_busy),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halt(halt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: every tx_start must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_rd) rd_cycles++;
    if (!rst && tx_start) begin
      tx_count++;
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tx_word", tx_word, exp_q.pop_front());
    end
  end

  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    rx_word  = w;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_resp(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("resp_arrived", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int r0;
    int t0;
    rst       = 1'b1;
    rx_ready  = 1'b0;
    rx_word   = '0;
    tx_busy   = 1'b0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_word", tx_word, 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // STATUS after reset: tx_start two cycles after rx_ready
    exp_q.push_back(32'h0);
    send_word(32'h0000_0001);
    @(negedge clk);
    check("status_latency", 32'(tx_start), 32'd1);
    wait_resp(20);

    // HALT
    exp_q.push_back(32'h0);
    send_word(32'h0000_0002);
    wait_resp(20);
    check("halt_set", 32'(halt), 32'd1);

    // MEM_WR 0x1000 <- 0xDEADBEEF, ack in third request cycle
    exp_q.push_back(32'h0);
    send_word(32'h0000_0005);
    send_word(32'h0000_1000);
    send_word(32'hDEAD_BEEF);
    check("wr_cycle1", 32'(mem_wr), 32'd1);
    check("wr_addr", mem_addr, 32'h0000_1000);
    check("wr_data", mem_wdata, 32'hDEAD_BEEF);
    check("wr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("wr_cycle2", 32'(mem_wr), 32'd1);
    @(negedge clk);
    check("wr_cycle3", 32'(mem_wr), 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("wr_dropped", 32'(mem_wr), 32'd0);
    wait_resp(20);

    // RESUME
    exp_q.push_back(32'h0);
    send_word(32'h0000_0003);
    wait_resp(20);
    check("halt_clear", 32'(halt), 32'd0);

    // MEM_RD while running: rejected, following word parsed as a new opcode
    r0 = rd_cycles;
    exp_q.push_back(32'hFFFF_FFFE);
    send_word(32'h0000_0004);
    wait_resp(20);
    exp_q.push_back(32'hFFFF_FFFF);
    send_word(32'h0000_2000);
    wait_resp(20);
    check("no_mem_rd", 32'(rd_cycles), 32'(r0));

    // HALT then MEM_RD 0x2000 returning 0x12345678
    exp_q.push_back(32'h0);
    send_word(32'h0000_0002);
    wait_resp(20);
    exp_q.push_back(32'h1234_5678);
    send_word(32'h0000_0004);
    send_word(32'h0000_2000);
    check("rd_req", 32'(mem_rd), 32'd1);
    check("rd_addr", mem_addr, 32'h0000_2000);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check("rd_dropped", 32'(mem_rd), 32'd0);
    wait_resp(20);

    // SEND holds off while transmitter busy
    tx_busy = 1'b1;
    t0 = tx_count;
    exp_q.push_back(32'h1);
    send_word(32'h0000_0001);
    repeat (4) @(negedge clk);
    check("send_waits_busy", 32'(tx_count), 32'(t0));
    tx_busy = 1'b0;
    wait_resp(20);

    // Argument timeout: partial MEM_WR abandoned silently after T+1 cycles
    t0 = tx_count;
    send_word(32'h0000_0005);
    n = 0;
    while (busy && n < T + 50) begin
      n++;
      @(negedge clk);
    end
    check("arg_timeout_len", 32'(n), 32'(T + 1));
    check("arg_timeout_silent", 32'(tx_count), 32'(t0));
    exp_q.push_back(32'h1);
    send_word(32'hABCD_EF01);
    wait_resp(20);

    // Unacknowledged MEM_RD with a stray word during the wait
    exp_q.push_back(32'hFFFF_FFFD);
    send_word(32'h0000_0004);
    send_word(32'h0000_3000);
    send_word(32'h0000_0055);
    n = 2;
    while (mem_rd && n < T + 50) begin
      n++;
      @(negedge clk);
    end
    check("ack_timeout_len", 32'(n), 32'(T + 1));
    wait_resp(20);
    exp_q.push_back(32'h3);
    send_word(32'h0000_0001);
    wait_resp(20);
    exp_q.push_back(32'h1);
    send_word(32'h0000_0001);
    wait_resp(20);

    // Reset in the middle of a write access
    send_word(32'h0000_0005);
    send_word(32'h0000_0010);
    send_word(32'h0000_0020);
    check("pre_rst_mem_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    check("mid_rst_halt", 32'(halt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Unknown opcode
    exp_q.push_back(32'hFFFF_FFFF);
    send_word(32'h0000_007F);
    wait_resp(20);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
